// File: rtl/excp_pkg.sv
// excp_pkg: shared CSR addresses, cause codes, bit indices and state types for the trap sequencer
package excp_pkg;

    localparam int XLEN = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_ECALL  = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_EBREAK = 32'd3;
    localparam logic [XLEN-1:0] CAUSE_EXT    = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_TIMER  = 32'h8000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    // Flush-request bit positions, also decoded by the pipeline controller
    localparam int FLUSH_EXCP = 0;
    localparam int FLUSH_IRQ  = 1;
    localparam int FLUSH_MRET = 2;

    localparam int STALL_ID = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MSTATUS, S_W_MRET, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        K_NONE, K_ECALL, K_EBREAK, K_EXT, K_TIMER, K_MRET
    } kind_t;

    // Trap entry: stash MIE into MPIE, disable interrupts, stay in machine mode
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and re-arm MPIE
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/excp_unit.sv
// excp_unit: machine-mode trap sequencer writing mepc/mcause/mstatus and redirecting fetch
module excp_unit
    import excp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_inst_addr_i,
    input  logic [2:0]      id_excp_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mie_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            excp_stallreq_o,
    output logic [2:0]      excp_flushreq_o,
    output logic            excp_jump_req_o,
    output logic [XLEN-1:0] excp_jump_addr_o
);

    state_t          state, state_nx;
    kind_t           kind_q, kind_nx;
    logic [XLEN-1:0] mepc_q, cause_q, cause_nx;
    logic            accept, irq_ext, irq_tmr;
    logic            unused_bits;

    assign unused_bits = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:0],
                           csr_mtvec_i[1:0], stall_i[5:3], stall_i[1:0]};

    // Event selection in IDLE; rst gates it so outputs are quiet while reset is held
    always_comb begin
        accept  = (state == S_IDLE) & id_valid_i & !stall_i[STALL_ID] & !rst;
        irq_ext = csr_mstatus_i[MSTATUS_MIE] & irq_ext_i & csr_mie_i[MIE_MEIE];
        irq_tmr = csr_mstatus_i[MSTATUS_MIE] & irq_timer_i & csr_mie_i[MIE_MTIE];
        kind_nx = !accept     ? K_NONE   :
                  irq_ext     ? K_EXT    :
                  irq_tmr     ? K_TIMER  :
                  id_excp_i[0] ? K_ECALL  :
                  id_excp_i[1] ? K_EBREAK :
                  id_excp_i[2] ? K_MRET   : K_NONE;
        cause_nx = kind_nx == K_EXT    ? CAUSE_EXT    :
                   kind_nx == K_TIMER  ? CAUSE_TIMER  :
                   kind_nx == K_ECALL  ? CAUSE_ECALL  :
                   kind_nx == K_EBREAK ? CAUSE_EBREAK : '0;
    end

    // State register and trap context captured at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            kind_q  <= K_NONE;
            mepc_q  <= '0;
            cause_q <= '0;
        end else begin
            state <= state_nx;
            if (kind_nx != K_NONE) begin
                kind_q  <= kind_nx;
                mepc_q  <= id_inst_addr_i;
                cause_q <= cause_nx;
            end
        end
    end

    // Next state and all request/CSR-port outputs
    always_comb begin
        state_nx         = state;
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        excp_stallreq_o  = 1'b0;
        excp_flushreq_o  = '0;
        excp_jump_req_o  = 1'b0;
        excp_jump_addr_o = '0;
        case (state)
            S_IDLE: if (kind_nx != K_NONE) begin
                excp_stallreq_o = 1'b1;
                excp_flushreq_o[FLUSH_IRQ]  = (kind_nx == K_EXT) | (kind_nx == K_TIMER);
                excp_flushreq_o[FLUSH_EXCP] = (kind_nx == K_ECALL) | (kind_nx == K_EBREAK);
                excp_flushreq_o[FLUSH_MRET] = kind_nx == K_MRET;
                state_nx = kind_nx == K_MRET ? S_W_MRET : S_W_MEPC;
            end
            S_W_MEPC: begin
                excp_stallreq_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = mepc_q;
                state_nx    = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                excp_stallreq_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                state_nx    = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                excp_stallreq_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(csr_mstatus_i);
                state_nx    = S_JUMP;
            end
            S_W_MRET: begin
                excp_stallreq_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(csr_mstatus_i);
                state_nx    = S_JUMP;
            end
            S_JUMP: begin
                excp_jump_req_o  = 1'b1;
                excp_jump_addr_o = kind_q == K_MRET ? csr_mepc_i : {csr_mtvec_i[XLEN-1:2], 2'b00};
                state_nx         = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: doc/excp_unit.md
# excp_unit

Machine-mode trap sequencer for the RV32 core; sits upstream of the pipeline controller and produces its exception stall, flush and jump requests. It detects ecall/ebreak/mret at the decode stage and enabled external/timer interrupts. It writes mepc/mcause/mstatus through a single CSR write port over successive cycles, then redirects fetch to mtvec, or to mepc for mret.

## Interface
- XLEN, 32, data/address width
- clk  input  1  core clock
- rst  input  1  reset; asynchronous and active-high
- stall_i  input  6  pipeline stall vector from ctrl; bit 2 = decode stalled
- id_valid_i  input  1  valid instruction in decode
- id_inst_addr_i  input  XLEN  PC of decode instruction
- id_excp_i  input  3  one-hot {mret, ebreak, ecall} from decode
- irq_ext_i / irq_timer_i  input  1 each  level interrupt requests, already synchronous to clk
- csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i  input  XLEN each  current CSR values
- csr_we_o  output  1  CSR write enable
- csr_waddr_o  output  12  CSR address
- csr_wdata_o  output  XLEN  CSR write data
- excp_stallreq_o  output  1  freeze pc/fetch/decode
- excp_flushreq_o  output  3  one-cycle pulse: [0] sync exception, [1] interrupt, [2] mret
- excp_jump_req_o  output  1  redirect fetch, one cycle
- excp_jump_addr_o  output  XLEN  redirect target

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, JUMP.
- Accept condition in IDLE: id_valid_i & !stall_i[2]. No events are accepted in any other state.
- irq_pend = mstatus.MIE(bit 3) & ((irq_ext_i & mie[11]) | (irq_timer_i & mie[7])).
- Priority: external irq > timer irq > ecall/ebreak > mret. An interrupt pre-empts the decode instruction; that instruction is flushed and re-executed after return.
- On accept, register:
  - mepc_q = id_inst_addr_i.
  - cause_q: ecall=11, ebreak=3, ext=0x8000000B, timer=0x80000007.
  - kind_q.
- Trap path: IDLE → W_MEPC → W_MCAUSE → W_MSTATUS → JUMP → IDLE.
  - W_MEPC writes 0x341 ← mepc_q.
  - W_MCAUSE writes 0x342 ← cause_q.
  - W_MSTATUS writes 0x300 ← mstatus with MPIE(7) = MIE and MIE = 0; MPP is left at 2'b11.
  - JUMP outputs addr = {mtvec[XLEN-1:2], 2'b00}. Only direct mode is supported; vectored mtvec is treated as direct.
- mret path: IDLE → W_MRET → JUMP → IDLE.
  - W_MRET writes 0x300 ← mstatus with MIE = MPIE and MPIE = 1.
  - JUMP outputs addr = csr_mepc_i.
- csr_we_o is 1 only in W_* states. csr_waddr_o and csr_wdata_o are 0 otherwise.
- Decode instructions without an id_excp_i bit and with no pending interrupt: no action.

## Timing
- Reset (async, immediate): state = IDLE; all outputs 0; mepc_q, cause_q, kind_q = 0.
- Accept at cycle T:
  - excp_flushreq_o (one bit) and excp_stallreq_o are asserted combinationally in T.
  - excp_stallreq_o stays high through every W_* state and is low in JUMP.
- Trap: CSR writes at T+1, T+2, T+3; jump at T+4; IDLE at T+5. The next accept is possible at T+5.
- mret: CSR write at T+1; jump at T+2.
- JUMP reads csr_mtvec_i and csr_mepc_i in the same cycle. The CSR file must make the write from the previous cycle visible (registered write, combinational read).
- Interrupt asserted while busy: ignored until IDLE. The level source must remain high to be taken.
- Interrupt arriving during the W_MSTATUS write: not taken, because MIE = 0 after the write.
- stall_i[2] high in IDLE: accept is deferred and no outputs are asserted.
- Reset mid-sequence: the partial CSR update is abandoned. No jump or flush is emitted after reset release.

## Structure
- Shared package excp_pkg:
  - CSR addresses (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342).
  - Cause codes.
  - mstatus bit indices (MIE 3, MPIE 7, MPP 12:11).
  - State enum.
  - Flush-request bit indices, shared with ctrl.
- Single module; no sub-module is needed.

## Test plan
- ecall at PC 0x100, mtvec = 0x8000_0201, MIE = 1:
  - flush[0] and stall at T.
  - Writes mepc = 0x100 (T+1), mcause = 11 (T+2), mstatus MIE = 0 / MPIE = 1 (T+3).
  - Jump to 0x8000_0200 at T+4.
- mret with mepc = 0x104, MPIE = 1, MIE = 0:
  - flush[2] at T.
  - mstatus MIE = 1 / MPIE = 1 at T+1.
  - Jump to 0x104 at T+2.
- irq_ext_i and irq_timer_i together with ebreak in decode at PC 0x200, mie[11] = mie[7] = 1:
  - flush[1]; mcause = 0x8000000B; mepc = 0x200.
- irq_timer_i high with MIE = 0, then MIE = 1 while stall_i[2] = 1:
  - No accept until stall_i[2] drops; then trap with mcause = 0x80000007.
- Second ecall presented while in W_MCAUSE:
  - Ignored; only one jump is emitted.
- rst asserted in W_MCAUSE:
  - All outputs drop to 0 immediately; after release there is no jump and no CSR write.
